mem_rw_arbiter: RTL and testbench

Round-robin front-end that shares one single-port `mem_rw` memory among `NUM_REQ` requesters. Each requester has its own valid/ready command port and read-response port. Accepted commands are registered and issued one per cycle onto the memory's `i_valid/i_addr/i_rw/i_data` pins. Read data returning on the memory's `o_data` is routed back to the requester that issued the read, tagged by requester index.

---
 rtl/mem_rw_pkg.sv | 22 ++
 rtl/mem_rw_arbiter_if.sv | 38 +++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/mem_rw_arbiter.sv | 64 ++++++
 tb/tb_mem_rw_arbiter.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_rw_pkg.sv
// Shared types for the mem_rw arbiter front-end.
// Widths, command bundle and read tag.
package mem_rw_pkg;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int MAX_REQ = 4;

  typedef logic [$clog2(MAX_REQ)-1:0] req_id_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              rw;
    logic [DATA_W-1:0] data;
  } mem_cmd_t;

  typedef struct packed {
    logic    pend;
    req_id_t id;
  } rd_tag_t;

endpackage

// File: rtl/mem_rw_arbiter_if.sv
// Requester command/response ports plus memory pins.
// master = requesters and memory, slave = arbiter.
interface mem_rw_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = mem_rw_pkg::ADDR_W,
  parameter int DATA_W  = mem_rw_pkg::DATA_W
);

  logic [NUM_REQ-1:0]             i_req_valid;
  logic [NUM_REQ-1:0]             o_req_ready;
  logic [NUM_REQ-1:0][ADDR_W-1:0] i_req_addr;
  logic [NUM_REQ-1:0]             i_req_rw;
  logic [NUM_REQ-1:0][DATA_W-1:0] i_req_data;
  logic [NUM_REQ-1:0]             o_rsp_valid;
  logic [DATA_W-1:0]              o_rsp_data;
  logic                           o_mem_valid;
  logic [ADDR_W-1:0]              o_mem_addr;
  logic                           o_mem_rw;
  logic [DATA_W-1:0]              o_mem_data;
  logic [DATA_W-1:0]              i_mem_data;

  modport master (
    output i_req_valid, i_req_addr, i_req_rw,
    output i_req_data, i_mem_data,
    input  o_req_ready, o_rsp_valid, o_rsp_data,
    input  o_mem_valid, o_mem_addr, o_mem_rw,
    input  o_mem_data
  );

  modport slave (
    input  i_req_valid, i_req_addr, i_req_rw,
    input  i_req_data, i_mem_data,
    output o_req_ready, o_rsp_valid, o_rsp_data,
    output o_mem_valid, o_mem_addr, o_mem_rw,
    output o_mem_data
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant from the
// request vector, pointer advances past each winner.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               adv,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     gnt_id
);

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] sel;
  logic           found;

  // first valid index at or after rr_ptr, cyclically
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    sel    = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel = IDW'((int'(rr_ptr) + i) % NUM_REQ);
      if (!found && req[sel]) begin
        found    = 1'b1;
        gnt[sel] = 1'b1;
        gnt_id   = sel;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rr_ptr <= '0;
    end else if (adv) begin
      if (gnt_id == IDW'(NUM_REQ - 1))
        rr_ptr <= '0;
      else
        rr_ptr <= gnt_id + 1'b1;
    end
  end

endmodule

// File: rtl/mem_rw_arbiter.sv
// Shares one single-port memory among NUM_REQ requesters;
// read data is steered back by a pipelined requester tag.
module mem_rw_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = mem_rw_pkg::ADDR_W,
  parameter int DATA_W  = mem_rw_pkg::DATA_W
) (
  input logic             i_clk,
  input logic             i_reset,
  mem_rw_arbiter_if.slave bus
);

  import mem_rw_pkg::*;

  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     gnt_id;
  logic               accept;
  rd_tag_t            tag;
  rd_tag_t            tag_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .req     (bus.i_req_valid),
    .adv     (accept),
    .gnt     (gnt),
    .gnt_id  (gnt_id)
  );

  assign accept          = |gnt;
  assign bus.o_req_ready = gnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bus.o_mem_valid <= 1'b0;
      bus.o_mem_addr  <= '0;
      bus.o_mem_rw    <= 1'b0;
      bus.o_mem_data  <= '0;
      tag             <= '0;
      tag_q           <= '0;
    end else begin
      bus.o_mem_valid <= accept;
      tag.pend        <= accept & ~bus.i_req_rw[gnt_id];
      tag_q           <= tag;
      if (accept) begin
        bus.o_mem_addr <= bus.i_req_addr[gnt_id];
        bus.o_mem_rw   <= bus.i_req_rw[gnt_id];
        bus.o_mem_data <= bus.i_req_data[gnt_id];
        tag.id         <= req_id_t'(gnt_id);
      end
    end
  end

  // memory output is registered, so data lines up with tag_q
  always_comb begin
    bus.o_rsp_valid = '0;
    bus.o_rsp_valid[tag_q.id[IDW-1:0]] = tag_q.pend;
  end

  assign bus.o_rsp_data = bus.i_mem_data;

endmodule

// File: tb/tb_mem_rw_arbiter.sv
// Directed bench for mem_rw_arbiter with a behavioural
// synchronous-read memory attached to the memory pins.
module tb_mem_rw_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_rw_arbiter_if #(.NUM_REQ(2)) bus ();
  mem_rw_arbiter_if #(.NUM_REQ(4)) bus4 ();

  mem_rw_arbiter #(.NUM_REQ(2)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  mem_rw_arbiter #(.NUM_REQ(4)) dut4 (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus4)
  );

  logic [31:0] mem [0:255];
  logic [31:0] mem_q = '0;

  always @(posedge clk) begin
    if (bus.o_mem_valid) begin
      if (bus.o_mem_rw) mem[bus.o_mem_addr] <= bus.o_mem_data;
      else mem_q <= mem[bus.o_mem_addr];
    end
  end

  assign bus.i_mem_data  = mem_q;
  assign bus4.i_mem_data = '0;

  task automatic idle();
    bus.i_req_valid  = '0;
    bus.i_req_rw     = '0;
    bus.i_req_addr   = '0;
    bus.i_req_data   = '0;
    bus4.i_req_valid = '0;
    bus4.i_req_rw    = '0;
    bus4.i_req_addr  = '0;
    bus4.i_req_data  = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.o_mem_addr !== 8'h00 || bus.o_mem_rw !== 1'b0) begin
      errors++;
      $display("FAIL reset_cmd: addr=%h rw=%b required 00/0",
               bus.o_mem_addr, bus.o_mem_rw);
    end
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      checks++;
      if (bus.o_mem_valid !== 1'b0 || bus.o_rsp_valid !== 2'b00 ||
          bus.o_req_ready !== 2'b00) begin
        errors++;
        $display("FAIL idle[%0d]: mv=%b rv=%b rdy=%b required 0/00/00",
                 c, bus.o_mem_valid, bus.o_rsp_valid, bus.o_req_ready);
      end
    end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    bus.i_req_valid   = 2'b01;
    bus.i_req_rw[0]   = 1'b1;
    bus.i_req_addr[0] = 8'h10;
    bus.i_req_data[0] = 32'hDEADBEEF;
    #1;
    checks++;
    if (bus.o_req_ready !== 2'b01) begin
      errors++;
      $display("FAIL wr_ready: got %b required 01", bus.o_req_ready);
    end
    @(negedge clk);
    bus.i_req_valid   = 2'b10;
    bus.i_req_rw      = 2'b00;
    bus.i_req_addr[1] = 8'h10;
    #1;
    checks++;
    if (bus.o_req_ready !== 2'b10 || bus.o_mem_valid !== 1'b1 ||
        bus.o_mem_rw !== 1'b1 || bus.o_mem_addr !== 8'h10 ||
        bus.o_mem_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_issue: rdy=%b mv=%b rw=%b a=%h d=%h required 10/1/1/10/deadbeef",
               bus.o_req_ready, bus.o_mem_valid, bus.o_mem_rw,
               bus.o_mem_addr, bus.o_mem_data);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (bus.o_mem_valid !== 1'b1 || bus.o_mem_rw !== 1'b0 ||
        bus.o_rsp_valid !== 2'b00) begin
      errors++;
      $display("FAIL rd_issue: mv=%b rw=%b rv=%b required 1/0/00",
               bus.o_mem_valid, bus.o_mem_rw, bus.o_rsp_valid);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.o_rsp_valid !== 2'b10 || bus.o_rsp_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rd_rsp: rv=%b d=%h required 10/deadbeef",
               bus.o_rsp_valid, bus.o_rsp_data);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.o_rsp_valid !== 2'b00 || bus.o_mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_done: rv=%b mv=%b required 00/0",
               bus.o_rsp_valid, bus.o_mem_valid);
    end
  endtask

  task automatic test_alternate();
    logic [1:0]  exp_g;
    logic [31:0] exp_d;
    mem[1] = 32'h11;
    mem[2] = 32'h22;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.i_req_valid   = (c < 8) ? 2'b11 : 2'b00;
      bus.i_req_rw      = 2'b00;
      bus.i_req_addr[0] = 8'h01;
      bus.i_req_addr[1] = 8'h02;
      #1;
      if (c < 8) begin
        exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
        checks++;
        if (bus.o_req_ready !== exp_g) begin
          errors++;
          $display("FAIL alt_grant[%0d]: got %b required %b",
                   c, bus.o_req_ready, exp_g);
        end
      end
      if (c >= 2) begin
        exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
        exp_d = (c % 2 == 0) ? 32'h11 : 32'h22;
        checks++;
        if (bus.o_rsp_valid !== exp_g || bus.o_rsp_data !== exp_d) begin
          errors++;
          $display("FAIL alt_rsp[%0d]: rv=%b d=%h required %b/%h",
                   c, bus.o_rsp_valid, bus.o_rsp_data, exp_g, exp_d);
        end
      end
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d [4];
    mem[0] = 32'hA0;
    mem[3] = 32'hA3;
    exp_d = '{32'hA0, 32'h11, 32'h22, 32'hA3};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      bus.i_req_valid   = (c < 4) ? 2'b10 : 2'b00;
      bus.i_req_rw      = 2'b00;
      bus.i_req_addr[1] = 8'(c);
      #1;
      if (c < 4) begin
        checks++;
        if (bus.o_req_ready !== 2'b10) begin
          errors++;
          $display("FAIL b2b_ready[%0d]: got %b required 10",
                   c, bus.o_req_ready);
        end
      end
      if (c >= 2) begin
        checks++;
        if (bus.o_rsp_valid !== 2'b10 || bus.o_rsp_data !== exp_d[c-2]) begin
          errors++;
          $display("FAIL b2b_rsp[%0d]: rv=%b d=%h required 10/%h",
                   c, bus.o_rsp_valid, bus.o_rsp_data, exp_d[c-2]);
        end
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.i_req_valid   = 2'b01;
    bus.i_req_rw      = 2'b00;
    bus.i_req_addr[0] = 8'h01;
    #1;
    checks++;
    if (bus.o_req_ready !== 2'b01) begin
      errors++;
      $display("FAIL mid_ready: got %b required 01", bus.o_req_ready);
    end
    @(negedge clk);
    idle();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.o_mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_flush: mv=%b required 0", bus.o_mem_valid);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      checks++;
      if (bus.o_rsp_valid !== 2'b00) begin
        errors++;
        $display("FAIL mid_norsp[%0d]: rv=%b required 00",
                 c, bus.o_rsp_valid);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    bus.i_req_valid   = 2'b11;
    bus.i_req_addr[0] = 8'h01;
    bus.i_req_addr[1] = 8'h02;
    #1;
    checks++;
    if (bus.o_req_ready !== 2'b01) begin
      errors++;
      $display("FAIL mid_ptr: got %b required 01", bus.o_req_ready);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (bus.o_rsp_valid !== 2'b00) begin
      errors++;
      $display("FAIL mid_quiet: rv=%b required 00", bus.o_rsp_valid);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.o_rsp_valid !== 2'b01 || bus.o_rsp_data !== 32'h11) begin
      errors++;
      $display("FAIL mid_rsp: rv=%b d=%h required 01/00000011",
               bus.o_rsp_valid, bus.o_rsp_data);
    end
  endtask

  task automatic test_four();
    logic [3:0] exp_g [3];
    logic [7:0] exp_a [3];
    exp_g = '{4'b0001, 4'b0100, 4'b1000};
    exp_a = '{8'h40, 8'h42, 8'h43};
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      bus4.i_req_valid = (c < 6) ? 4'b1101 : 4'b0000;
      bus4.i_req_rw    = '0;
      for (int k = 0; k < 4; k++) bus4.i_req_addr[k] = 8'(8'h40 + k);
      #1;
      if (c < 6) begin
        checks++;
        if (bus4.o_req_ready !== exp_g[c % 3]) begin
          errors++;
          $display("FAIL four_grant[%0d]: got %b required %b",
                   c, bus4.o_req_ready, exp_g[c % 3]);
        end
      end
      if (c >= 1) begin
        checks++;
        if (bus4.o_mem_valid !== 1'b1 ||
            bus4.o_mem_addr !== exp_a[(c - 1) % 3]) begin
          errors++;
          $display("FAIL four_addr[%0d]: mv=%b a=%h required 1/%h",
                   c, bus4.o_mem_valid, bus4.o_mem_addr,
                   exp_a[(c - 1) % 3]);
        end
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_write_read();
    test_alternate();
    test_back_to_back();
    test_reset_mid();
    test_four();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
